bounce_gen: RTL



---
 rtl/bounce_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bounce_gen.sv
// bounce_gen: contact-bounce emulator; turns a clean level request into a burst of
//   random pulses toward the new level, separated by random gaps, then a stable level.
// Latency: first d_o edge toward a new level one clock after d_i is seen differing.
// Backpressure: none; d_i changes during a burst are ignored until the burst settles.
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   d_i    clean requested switch level (must already be synchronous to clk)
//   d_o    bouncy switch output (registered)
//   busy   high while bounce pulses/gaps are being emitted
//   done   one-cycle pulse when d_o settles at the new level
//   byp    only with BOUNCE_GEN_BYPASS_EN defined: d_o follows d_i with one clock delay
//
// Optional feature macro: BOUNCE_GEN_BYPASS_EN (adds the byp input).
module bounce_gen #(
  parameter int          NB   = 80,
  parameter int          PMIN = 2,
  parameter int          PRW  = 8,
  parameter int          GMIN = 500,
  parameter int          GRW  = 13,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
`ifdef BOUNCE_GEN_BYPASS_EN
  input  logic byp,
`endif
  output logic d_o,
  output logic busy,
  output logic done
);

  localparam int PLEN_MAX = PMIN + (1 << PRW);
  localparam int GLEN_MAX = GMIN + (1 << GRW);
  localparam int TMAX     = (PLEN_MAX > GLEN_MAX) ? PLEN_MAX : GLEN_MAX;
  localparam int TW       = $clog2(TMAX) + 1;
  // Bounce counter must hold 0..NB; keep at least one bit when bounce is disabled.
  localparam int CW       = (NB < 1) ? 1 : $clog2(NB + 1);

  localparam logic [CW-1:0] NB_C = CW'(NB);
  localparam logic [TW-1:0] ONE_T = TW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PULSE  = 2'd1,
    S_GAP    = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  state_t          r_state;
  logic [15:0]     r_lfsr;
  logic [TW-1:0]   r_timer;
  logic [CW-1:0]   r_cnt;
  logic            r_target;
  logic            r_settled;
  logic            r_dout;
  logic            r_busy;
  logic            r_done;

  logic [15:0]     w_lfsr_nxt;
  logic [TW-1:0]   w_plen;
  logic [TW-1:0]   w_glen;

  // Galois LFSR, x^16+x^14+x^13+x^11+1 (right-shifting form, tap mask 0xB400).
  assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);

  // Durations are drawn from the LFSR value present at the state-entry edge.
  assign w_plen = TW'(PMIN) + {{(TW - PRW){1'b0}}, r_lfsr[PRW-1:0]};
  assign w_glen = TW'(GMIN) + {{(TW - GRW){1'b0}}, r_lfsr[GRW-1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lfsr    <= SEED;
      r_timer   <= '0;
      r_cnt     <= '0;
      r_target  <= 1'b0;
      r_settled <= 1'b0;
      r_dout    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end
`ifdef BOUNCE_GEN_BYPASS_EN
    else if (byp) begin
      // Bypass aborts any burst; the LFSR keeps free-running.
      r_lfsr    <= w_lfsr_nxt;
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dout    <= d_i;
      r_settled <= d_i;
    end
`endif
    else begin
      r_lfsr <= w_lfsr_nxt;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_dout <= r_settled;
          if (d_i != r_settled) begin
            r_target <= d_i;
            r_cnt    <= '0;
            r_dout   <= d_i;
            if (NB == 0) begin
              // No bounce: straight to the settle cycle, busy never asserted.
              r_state   <= S_SETTLE;
              r_settled <= d_i;
              r_done    <= 1'b1;
            end else begin
              r_state <= S_PULSE;
              r_busy  <= 1'b1;
              r_timer <= w_plen;
            end
          end
        end

        S_PULSE: begin
          if (r_timer == ONE_T) begin
            r_state <= S_GAP;
            r_dout  <= ~r_target;
            r_timer <= w_glen;
            r_cnt   <= r_cnt + CW'(1);
          end else begin
            r_timer <= r_timer - ONE_T;
          end
        end

        S_GAP: begin
          if (r_timer == ONE_T) begin
            r_dout <= r_target;
            if (r_cnt < NB_C) begin
              r_state <= S_PULSE;
              r_timer <= w_plen;
            end else begin
              r_state   <= S_SETTLE;
              r_settled <= r_target;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end
          end else begin
            r_timer <= r_timer - ONE_T;
          end
        end

        S_SETTLE: begin
          // settled already equals target, so IDLE cannot re-trigger before
          // seeing d_i for at least one full cycle.
          r_state <= S_IDLE;
          r_dout  <= r_settled;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign d_o  = r_dout;
  assign busy = r_busy;
  assign done = r_done;

endmodule
